// File: rtl/icache_pkg.sv
// icache_pkg: shared fill-controller types, line geometry and address helpers.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        REPLAY
    } state_e;

    localparam int LINE_WORDS = 4;
    localparam int OFF_W      = $clog2(LINE_WORDS) + 2;

    // All-ones above the line offset; truncate to the address width at the use site.
    function automatic logic [63:0] line_mask(input int off);
        return ~64'd0 << off;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst)
            count_q <= '0;
        else if (inc && !(&count_q))
            count_q <= count_q + 1'b1;
    end

    assign count = count_q;

endmodule

// File: rtl/icache_fill_ctrl.sv
// icache_fill_ctrl: stalls fetch on a miss, refills the line word by word over
// req/ack, validates it, and flushes IF/ID if a redirect overlapped the fill.
module icache_fill_ctrl #(
    parameter int LINE_WORDS = icache_pkg::LINE_WORDS,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              hit,
    input  logic              pc_src,
    output logic              stall,
    output logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              fill_we,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [DATA_W-1:0] fill_data,
    output logic              tag_we,
    output logic [CNT_W-1:0]  miss_count
);

    import icache_pkg::*;

    localparam int OFF  = $clog2(LINE_WORDS) + 2;
    localparam int WC_W = $clog2(LINE_WORDS);
    localparam logic [ADDR_W-1:0] MASK = ADDR_W'(line_mask(OFF));

    state_e            state_q;
    logic [ADDR_W-1:0] base_q;
    logic [WC_W-1:0]   wc_q;
    logic              redir_q;
    logic              flush_q;
    logic              miss;
    logic              last;

    assign miss = (state_q == IDLE) && req_valid && !hit;
    assign last = wc_q == WC_W'(LINE_WORDS - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            wc_q    <= '0;
            redir_q <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            flush_q <= 1'b0;
            case (state_q)
                IDLE: if (miss) begin
                    base_q  <= req_addr & MASK;
                    wc_q    <= '0;
                    state_q <= FILL;
                end
                FILL: begin
                    if (pc_src)
                        redir_q <= 1'b1;
                    if (mem_ack) begin
                        wc_q <= wc_q + 1'b1;
                        if (last)
                            state_q <= REPLAY;
                    end
                end
                REPLAY: begin
                    // A redirect in the replay cycle itself must still flush.
                    flush_q <= redir_q || pc_src;
                    redir_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stall     = miss || (state_q != IDLE);
    assign flush     = flush_q;
    assign mem_req   = state_q == FILL;
    assign mem_addr  = base_q + (ADDR_W'(wc_q) << 2);
    assign fill_we   = mem_req && mem_ack;
    assign fill_addr = mem_addr;
    assign fill_data = mem_rdata;
    assign tag_we    = fill_we && last;

    sat_counter #(.WIDTH(CNT_W)) u_miss_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (miss),
        .count (miss_count)
    );

endmodule

// File: doc/icache_fill_ctrl.md
# icache_fill_ctrl

Miss/refill controller for the instruction fetch stage's cache. It watches the fetch lookup each cycle and stalls the PC on a miss. It then sequences a multi-word line fill from main memory over a req/ack handshake and writes each returned word into the cache array. Finally it re-validates the line and releases the pipeline, tracking redirects (`pc_src`) that arrive while the fill is in progress.

## Interface
- `LINE_WORDS`, 4, words per cache line; power of two, ≥2
- `ADDR_W`, 32, byte address width
- `DATA_W`, 32, instruction word width
- `CNT_W`, 16, miss-counter width

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high
- `req_valid` in 1: fetch performs a cache lookup this cycle
- `req_addr` in ADDR_W: PC of that lookup
- `hit` in 1: tag hit for `req_addr`
- `pc_src` in 1: redirect to branch target this cycle
- `stall` out 1: hold PC and IF/ID register
- `flush` out 1: one-cycle bubble into IF/ID after a fill overlapped by a redirect
- `mem_req` out 1: memory read request
- `mem_addr` out ADDR_W: word-aligned read address
- `mem_ack` in 1: `mem_rdata` valid; one word per ack
- `mem_rdata` in DATA_W: returned word
- `fill_we` out 1: write `fill_data` at `fill_addr` into the data array
- `fill_addr` out ADDR_W: byte address of the word being written
- `fill_data` out DATA_W: word being written
- `tag_we` out 1: write tag and set the valid bit for the line containing `fill_addr`
- `miss_count` out CNT_W: saturating miss counter

## Operation
- OFF_W = log2(LINE_WORDS)+2. Line base = `req_addr` with its low OFF_W bits cleared.
- State machine, three states:
  - **IDLE**
    - Miss when `req_valid & ~hit`: latch line base, clear `word_cnt`, increment `miss_count`, go FILL.
  - **FILL**
    - `mem_req`=1.
    - `mem_addr` = line base + `word_cnt`·4. Request and address stay stable until ack.
    - On `mem_ack`: `fill_we`=1, `fill_data`=`mem_rdata`, `fill_addr`=`mem_addr` (all combinational that cycle); `word_cnt`++.
    - The ack with `word_cnt`==LINE_WORDS-1 also pulses `tag_we`; go REPLAY.
  - **REPLAY**
    - One cycle, lets the array write settle. `mem_req`=0. Go IDLE.
- Fill order is always sequential from word 0 (no critical-word-first).
- `stall` = (IDLE & `req_valid` & ~`hit`) | FILL | REPLAY. It is combinational, so it is high in the miss cycle itself.
- Redirect tracking:
  - `pc_src` in FILL or REPLAY sets `redir_pend`.
  - The fill is never aborted; the line is still written and validated.
  - In the IDLE cycle after REPLAY: `flush`=1 if `redir_pend` was set, then clear it.
  - `pc_src` in IDLE has no effect on the controller.
- `miss_count` saturates at all-ones and never wraps.
- Outputs are only meaningful in their states: `fill_we`/`tag_we`/`mem_req` are 0 outside FILL, and `mem_addr` is don't-care when `mem_req`=0.

## Timing
- Reset values: state IDLE, `stall`=0 unless a combinational miss is present, `flush`=0, `mem_req`=0, `fill_we`=0, `tag_we`=0, `miss_count`=0, `redir_pend`=0, `word_cnt`=0.
- Miss penalty:
  - Minimum, with ack every cycle: `stall` high for LINE_WORDS+2 consecutive cycles.
  - With LINE_WORDS=4: miss cycle 0, FILL 1–4, REPLAY 5, hit lookup in cycle 6.
  - Each cycle without an ack in FILL adds exactly one stall cycle.
- `mem_ack` is ignored outside FILL; a stray ack writes nothing.
- A miss in the IDLE cycle right after REPLAY (new PC after redirect) starts a new fill with no gap cycle. `flush` and `stall` may both be 1 in that cycle.
- `rst` mid-fill: next edge goes to IDLE with `mem_req`=0 and all counters cleared. The partially written line is never validated (`tag_we` not pulsed). Memory must tolerate a withdrawn request.

## Structure
- Shared package `icache_pkg`:
  - state enum (IDLE/FILL/REPLAY)
  - `LINE_WORDS` and derived `OFF_W`
  - line-base mask function
- One sub-module `sat_counter` (parameter width; `clk`, `rst`, `inc`, `count`) for `miss_count`.
- Everything else inline.

## Test plan
- Hit stream: `req_valid`=1, `hit`=1 for 20 cycles → `stall`=0, `mem_req`=0, `miss_count`=0.
- Miss at `req_addr`=0x0000_0048, ack every cycle:
  - `mem_addr` = 0x40, 0x44, 0x48, 0x4C
  - four `fill_we`; `tag_we` with the 0x4C word
  - `stall` high exactly 6 cycles; `miss_count`=1
- Same miss with ack every 3rd cycle → each word's address held until its ack; `stall` high 3·4+2=14 cycles.
- `pc_src` pulsed during FILL word 2 → fill completes, `tag_we` still asserted, `flush`=1 for exactly the cycle after REPLAY.
- `rst` asserted after 2 acks → next cycle IDLE, `mem_req`=0, no `tag_we`, `miss_count`=0; a later miss refetches from word 0.
- With `CNT_W`=4, force 17 misses → `miss_count` stays 0xF.
